// File: rtl/ips2l_pcie_dma_mwr_rx_ctrl_if.sv
// ----------------------------------------------------------------------------
// ips2l_pcie_dma_mwr_rx_ctrl_if
// AXI-stream TLP channel from the PCIe core (source) to the MWr receive
// controller (sink).
//   tvld  : beat valid           (source -> sink)
//   trdy  : beat ready           (sink -> source)
//   tdata : 128-bit beat data    (source -> sink)
//   tlast : last beat of the TLP (source -> sink)
// ----------------------------------------------------------------------------
interface ips2l_pcie_dma_mwr_rx_ctrl_if;
    logic         tvld;
    logic         trdy;
    logic [127:0] tdata;
    logic         tlast;

    modport master (output tvld, output tdata, output tlast, input  trdy);
    modport slave  (input  tvld, input  tdata, input  tlast, output trdy);
endinterface

// File: rtl/ips2l_pcie_dma_mwr_rx_ctrl.sv
// ----------------------------------------------------------------------------
// ips2l_pcie_dma_mwr_rx_ctrl
// Receive side of the DMA memory-write path. Takes posted MWr TLPs (3DW/4DW
// header beat followed by 128-bit payload beats), byte-swaps every payload DW
// from wire order to little-endian and writes it into the DMA buffer RAM with
// per-DW byte enables. Non-MWr TLPs, unaligned MWr and length/tlast mismatches
// are dropped and counted.
// Ports:
//   clk, rst          : core clock, synchronous active-high reset
//   axis_master       : TLP stream (slave modport)
//   i_wr_hold         : RAM backpressure, deasserts trdy
//   o_wr_en/addr/data/be : RAM write port, 1 clk after beat acceptance
//   o_tlp_done        : pulse with the final write of a good MWr
//   o_tlp_len/tag/req_id : header fields of the last good MWr
//   o_err_malformed   : sticky malformed flag
//   o_drop_cnt        : saturating dropped-TLP count
//   i_cnt_clr         : clears o_drop_cnt and o_err_malformed
// ----------------------------------------------------------------------------
module ips2l_pcie_dma_mwr_rx_ctrl #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    ips2l_pcie_dma_mwr_rx_ctrl_if.slave axis_master,
    input  logic                        i_wr_hold,
    output logic                        o_wr_en,
    output logic [ADDR_W-1:0]           o_wr_addr,
    output logic [127:0]                o_wr_data,
    output logic [15:0]                 o_wr_be,
    output logic                        o_tlp_done,
    output logic [9:0]                  o_tlp_len,
    output logic [7:0]                  o_tlp_tag,
    output logic [15:0]                 o_tlp_req_id,
    output logic                        o_err_malformed,
    output logic [15:0]                 o_drop_cnt,
    input  logic                        i_cnt_clr
);

    typedef enum logic [1:0] {HDR, DATA, DROP} state_e;

    state_e state_q, state_d;
    logic   rst_q;

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [10:0]       rem_q, rem_d;      // remaining DWs, 1..1024
    logic              first_q, first_d;
    logic              one_dw_q, one_dw_d;
    logic [3:0]        fbe_q, fbe_d, lbe_q, lbe_d;
    logic [9:0]        len_q, len_d;
    logic [7:0]        tag_q, tag_d;
    logic [15:0]       rid_q, rid_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [127:0]      wr_data_q, wr_data_d;
    logic [15:0]       wr_be_q, wr_be_d;
    logic              done_q, done_d;
    logic [9:0]        tlp_len_q, tlp_len_d;
    logic [7:0]        tlp_tag_q, tlp_tag_d;
    logic [15:0]       tlp_rid_q, tlp_rid_d;
    logic              err_q, err_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              beat_acc;
    logic [7:0]        fmt_type;
    logic              is_4dw, is_mwr, hdr_misalign;
    logic [ADDR_W-1:0] hdr_ptr;
    logic              last_beat;
    logic [127:0]      swap_data;
    logic [15:0]       beat_be;
    logic              drop_inc, err_set;

    assign axis_master.trdy = ~rst_q & ~i_wr_hold;
    assign beat_acc         = axis_master.tvld & axis_master.trdy;

    // Header decode; the low address DW is DW2 for 3DW and DW3 for 4DW
    assign fmt_type     = axis_master.tdata[31:24];
    assign is_4dw       = (fmt_type == 8'h60);
    assign is_mwr       = (fmt_type == 8'h40) | is_4dw;
    assign hdr_misalign = is_4dw ? (|axis_master.tdata[99:98]) : (|axis_master.tdata[67:66]);
    assign hdr_ptr      = is_4dw ? axis_master.tdata[ADDR_W+99:100] : axis_master.tdata[ADDR_W+67:68];
    assign last_beat    = (rem_q <= 11'd4);

    always_comb begin
        swap_data = '0;
        beat_be   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            swap_data[i*32 +: 32] = {axis_master.tdata[i*32 +: 8], axis_master.tdata[i*32+8 +: 8],
                                     axis_master.tdata[i*32+16 +: 8], axis_master.tdata[i*32+24 +: 8]};
            if (11'(i) < rem_q) beat_be[i*4 +: 4] = 4'hF;
            if (i == 0 && first_q) beat_be[3:0] = fbe_q;
            // last_be goes on the highest valid lane; a 1-DW TLP uses first_be only
            if (last_beat && !one_dw_q && (11'(i) + 11'd1 == rem_q)) beat_be[i*4 +: 4] = lbe_q;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q    <= HDR;
            ptr_q      <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            one_dw_q   <= 1'b0;
            fbe_q      <= '0;
            lbe_q      <= '0;
            len_q      <= '0;
            tag_q      <= '0;
            rid_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            done_q     <= 1'b0;
            tlp_len_q  <= '0;
            tlp_tag_q  <= '0;
            tlp_rid_q  <= '0;
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            one_dw_q   <= one_dw_d;
            fbe_q      <= fbe_d;
            lbe_q      <= lbe_d;
            len_q      <= len_d;
            tag_q      <= tag_d;
            rid_q      <= rid_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
            done_q     <= done_d;
            tlp_len_q  <= tlp_len_d;
            tlp_tag_q  <= tlp_tag_d;
            tlp_rid_q  <= tlp_rid_d;
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (beat_acc) begin
            unique case (state_q)
                HDR: begin
                    if (axis_master.tlast)            state_d = HDR;
                    else if (!is_mwr || hdr_misalign) state_d = DROP;
                    else                              state_d = DATA;
                end
                DATA: begin
                    if (axis_master.tlast) state_d = HDR;
                    else if (last_beat)    state_d = DROP;
                end
                DROP: begin
                    if (axis_master.tlast) state_d = HDR;
                end
                default: state_d = HDR;
            endcase
        end
    end

    // Datapath / output logic
    always_comb begin
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        first_d   = first_q;
        one_dw_d  = one_dw_q;
        fbe_d     = fbe_q;
        lbe_d     = lbe_q;
        len_d     = len_q;
        tag_d     = tag_q;
        rid_d     = rid_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_be_d   = wr_be_q;
        done_d    = 1'b0;
        tlp_len_d = tlp_len_q;
        tlp_tag_d = tlp_tag_q;
        tlp_rid_d = tlp_rid_q;
        drop_inc  = 1'b0;
        err_set   = 1'b0;

        if (beat_acc && state_q == HDR) begin
            ptr_d    = hdr_ptr;
            rem_d    = (axis_master.tdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, axis_master.tdata[9:0]};
            first_d  = 1'b1;
            one_dw_d = (axis_master.tdata[9:0] == 10'd1);
            fbe_d    = axis_master.tdata[35:32];
            lbe_d    = axis_master.tdata[39:36];
            len_d    = axis_master.tdata[9:0];
            tag_d    = axis_master.tdata[47:40];
            rid_d    = axis_master.tdata[63:48];
            drop_inc = axis_master.tlast | ~is_mwr | hdr_misalign;
            err_set  = is_mwr & (axis_master.tlast | hdr_misalign);
        end else if (beat_acc && state_q == DATA) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = swap_data;
            wr_be_d   = beat_be;
            ptr_d     = ptr_q + 1'b1;
            rem_d     = last_beat ? 11'd0 : rem_q - 11'd4;
            first_d   = 1'b0;
            if (axis_master.tlast && last_beat) begin
                done_d    = 1'b1;
                tlp_len_d = len_q;
                tlp_tag_d = tag_q;
                tlp_rid_d = rid_q;
            end else if (axis_master.tlast || last_beat) begin
                drop_inc = 1'b1;
                err_set  = 1'b1;
            end
        end

        // Clear has priority over a same-cycle increment or set
        if (i_cnt_clr) begin
            err_d      = 1'b0;
            drop_cnt_d = '0;
        end else begin
            err_d      = err_q | err_set;
            drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        end
    end

    assign o_wr_en         = wr_en_q;
    assign o_wr_addr       = wr_addr_q;
    assign o_wr_data       = wr_data_q;
    assign o_wr_be         = wr_be_q;
    assign o_tlp_done      = done_q;
    assign o_tlp_len       = tlp_len_q;
    assign o_tlp_tag       = tlp_tag_q;
    assign o_tlp_req_id    = tlp_rid_q;
    assign o_err_malformed = err_q;
    assign o_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_ips2l_pcie_dma_mwr_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ips2l_pcie_dma_mwr_rx_ctrl
// Drives MWr / non-MWr TLPs into the receive controller. Expected RAM writes
// are derived per payload DW index and queued when a TLP is issued; a monitor
// pops and compares on every o_wr_en.
// ----------------------------------------------------------------------------
module tb_ips2l_pcie_dma_mwr_rx_ctrl;
    localparam int AW = 10;

    typedef struct {
        logic [AW-1:0] addr;
        logic [127:0]  data;
        logic [15:0]   be;
        bit            done;
        logic [9:0]    len;
        logic [7:0]    tag;
        logic [15:0]   rid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ips2l_pcie_dma_mwr_rx_ctrl_if bus ();
    logic          i_wr_hold = 1'b0;
    logic          i_cnt_clr = 1'b0;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [127:0]  o_wr_data;
    logic [15:0]   o_wr_be;
    logic          o_tlp_done;
    logic [9:0]    o_tlp_len;
    logic [7:0]    o_tlp_tag;
    logic [15:0]   o_tlp_req_id;
    logic          o_err_malformed;
    logic [15:0]   o_drop_cnt;

    ips2l_pcie_dma_mwr_rx_ctrl #(.ADDR_W(AW)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .axis_master     (bus.slave),
        .i_wr_hold       (i_wr_hold),
        .o_wr_en         (o_wr_en),
        .o_wr_addr       (o_wr_addr),
        .o_wr_data       (o_wr_data),
        .o_wr_be         (o_wr_be),
        .o_tlp_done      (o_tlp_done),
        .o_tlp_len       (o_tlp_len),
        .o_tlp_tag       (o_tlp_tag),
        .o_tlp_req_id    (o_tlp_req_id),
        .o_err_malformed (o_err_malformed),
        .o_drop_cnt      (o_drop_cnt),
        .i_cnt_clr       (i_cnt_clr)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_drop = 0;
    bit   exp_err = 1'b0;
    int   done_seen = 0;
    bit   hold_en = 1'b0, gap_en = 1'b0, clr_with_beat = 1'b0, mon_en = 1'b0;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [127:0] mk_hdr(input logic [7:0] ft, input logic [9:0] len,
                                            input logic [3:0] fbe, input logic [3:0] lbe,
                                            input logic [7:0] tag, input logic [15:0] rid,
                                            input logic [63:0] addr);
        logic [31:0] dw2, dw3;
        if (ft == 8'h60) begin
            dw2 = addr[63:32];
            dw3 = addr[31:0];
        end else begin
            dw2 = addr[31:0];
            dw3 = $urandom;
        end
        return {dw3, dw2, rid, tag, lbe, fbe, ft, 14'h0, len};
    endfunction

    // Expected write for payload beat b: lane byte enables follow the DW index
    function automatic exp_t mk_exp(input logic [127:0] d, input int b, input int total,
                                    input logic [3:0] fbe, input logic [3:0] lbe,
                                    input logic [AW-1:0] w0, input bit done,
                                    input logic [9:0] len, input logic [7:0] tag,
                                    input logic [15:0] rid);
        exp_t e;
        e.addr = w0 + AW'(b);
        e.be   = '0;
        for (int lane = 0; lane < 4; lane++) begin
            int k;
            k = b * 4 + lane;
            e.data[lane*32 +: 32] = bswap(d[lane*32 +: 32]);
            if (k >= total)          e.be[lane*4 +: 4] = 4'h0;
            else if (k == 0)         e.be[lane*4 +: 4] = fbe;
            else if (k == total - 1) e.be[lane*4 +: 4] = lbe;
            else                     e.be[lane*4 +: 4] = 4'hF;
        end
        e.done = done;
        e.len  = len;
        e.tag  = tag;
        e.rid  = rid;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_beat(input logic [127:0] d, input bit last);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc) begin
            @(negedge clk);
            i_wr_hold = hold_en ? ($urandom_range(0, 3) == 0) : 1'b0;
            i_cnt_clr = clr_with_beat;
            if (gap_en && $urandom_range(0, 4) == 0) begin
                bus.tvld = 1'b0;
            end else begin
                bus.tvld  = 1'b1;
                bus.tdata = d;
                bus.tlast = last;
            end
            #1;
            acc = bus.tvld && bus.trdy;
            n++;
            if (!acc && n > 200) begin
                n_cmp++;
                n_mis++;
                $display("FAIL beat_accept_timeout: got no trdy expected accept within 200 cycles");
                acc = 1'b1;
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.tvld  = 1'b0;
        bus.tlast = 1'b0;
        i_wr_hold = 1'b0;
        i_cnt_clr = 1'b0;
    endtask

    task automatic checkpoint(input bit with_err);
        go_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        chk("drop_cnt", 64'(o_drop_cnt), 64'(exp_drop));
        if (with_err) chk("err_malformed", 64'(o_err_malformed), 64'(exp_err));
    endtask

    // MWr with 'sent' payload beats; sent != ceil(len/4) is a malformed TLP
    task automatic run_mwr(input bit is4, input logic [63:0] addr, input logic [9:0] len,
                           input logic [3:0] fbe, input logic [3:0] lbe, input int sent,
                           input logic [31:0] first_dw, input logic [7:0] tag,
                           input logic [15:0] rid);
        int total, need;
        logic [127:0] beats[$];
        total = (len == 10'd0) ? 1024 : int'(len);
        need  = (total + 3) / 4;
        for (int b = 0; b < sent; b++) begin
            logic [127:0] d;
            d = {$urandom, $urandom, $urandom, $urandom};
            if (b == 0) d[31:0] = first_dw;
            beats.push_back(d);
            if (b < need)
                sb.push_back(mk_exp(d, b, total, fbe, lbe, addr[AW+3:4],
                                    (sent == need) && (b == need - 1), len, tag, rid));
        end
        if (sent != need) begin
            exp_drop++;
            exp_err = 1'b1;
        end
        drive_beat(mk_hdr(is4 ? 8'h60 : 8'h40, len, fbe, lbe, tag, rid, addr), sent == 0);
        for (int b = 0; b < sent; b++) drive_beat(beats[b], b == sent - 1);
    endtask

    task automatic send_drop(input logic [127:0] hdr, input int nbeats);
        exp_drop++;
        drive_beat(hdr, nbeats == 1);
        for (int b = 1; b < nbeats; b++)
            drive_beat({$urandom, $urandom, $urandom, $urandom}, b == nbeats - 1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        i_cnt_clr = 1'b1;
        @(negedge clk);
        i_cnt_clr = 1'b0;
        exp_drop = 0;
        exp_err  = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_wr_en) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_write: got write addr=%h be=%h expected no write", o_wr_addr, o_wr_be);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_cmp++;
                    if (o_wr_addr !== e.addr || o_wr_data !== e.data || o_wr_be !== e.be || o_tlp_done !== e.done) begin
                        n_mis++;
                        $display("FAIL write: got addr=%h be=%h done=%b data=%h expected addr=%h be=%h done=%b data=%h",
                                 o_wr_addr, o_wr_be, o_tlp_done, o_wr_data, e.addr, e.be, e.done, e.data);
                    end
                    if (e.done) begin
                        n_cmp++;
                        if ({o_tlp_len, o_tlp_tag, o_tlp_req_id} !== {e.len, e.tag, e.rid}) begin
                            n_mis++;
                            $display("FAIL tlp_info: got len=%h tag=%h rid=%h expected len=%h tag=%h rid=%h",
                                     o_tlp_len, o_tlp_tag, o_tlp_req_id, e.len, e.tag, e.rid);
                        end
                    end
                end
            end else if (o_tlp_done) begin
                n_cmp++;
                n_mis++;
                $display("FAIL done_without_write: got o_tlp_done=1 expected 0");
            end
            if (o_tlp_done) done_seen++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected end of test");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1);
    end

    initial begin
        int done0;
        bus.tvld  = 1'b0;
        bus.tlast = 1'b0;
        bus.tdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_trdy", 64'(bus.trdy), 64'd0);
        chk("rst_wr_en", 64'(o_wr_en), 64'd0);
        chk("rst_wr_addr", 64'(o_wr_addr), 64'd0);
        chk("rst_done", 64'(o_tlp_done), 64'd0);
        chk("rst_drop", 64'(o_drop_cnt), 64'd0);
        chk("rst_err", 64'(o_err_malformed), 64'd0);
        chk("rst_info", 64'({o_tlp_len, o_tlp_tag, o_tlp_req_id}), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed cases
        run_mwr(1'b0, 64'h100, 10'd8, 4'hF, 4'hF, 2, 32'h11223344, 8'h5A, 16'hBEEF);
        checkpoint(1'b1);
        chk("t1_tag", 64'(o_tlp_tag), 64'h5A);
        chk("t1_req_id", 64'(o_tlp_req_id), 64'hBEEF);
        run_mwr(1'b1, 64'h1_0000_0020, 10'd1, 4'h3, 4'h9, 1, $urandom, 8'h01, 16'h0102);
        run_mwr(1'b0, 64'h200, 10'd6, 4'hE, 4'h7, 2, $urandom, 8'h02, 16'h0203);
        checkpoint(1'b1);
        chk("t2t3_len", 64'(o_tlp_len), 64'd6);

        send_drop(mk_hdr(8'h00, 10'd1, 4'hF, 4'h0, 8'h03, 16'h1, 64'h400), 1);
        send_drop(mk_hdr(8'h4A, 10'd8, 4'h0, 4'h0, 8'h04, 16'h1, 64'h0), 3);
        checkpoint(1'b0);
        pulse_clr();
        checkpoint(1'b1);

        // Clear in the same cycle as a counted drop
        clr_with_beat = 1'b1;
        send_drop(mk_hdr(8'h00, 10'd1, 4'hF, 4'h0, 8'h05, 16'h1, 64'h400), 1);
        clr_with_beat = 1'b0;
        exp_drop = 0;
        checkpoint(1'b0);
        send_drop(mk_hdr(8'h00, 10'd1, 4'hF, 4'h0, 8'h06, 16'h1, 64'h400), 1);
        checkpoint(1'b0);
        pulse_clr();

        // Short, long, unaligned, wrap, 1024-DW
        run_mwr(1'b0, 64'h300, 10'd8, 4'hF, 4'hF, 1, $urandom, 8'h07, 16'h0707);
        checkpoint(1'b1);
        run_mwr(1'b0, 64'h340, 10'd5, 4'hC, 4'h1, 2, $urandom, 8'h08, 16'h0808);
        checkpoint(1'b1);
        run_mwr(1'b1, 64'h2_0000_0400, 10'd4, 4'hF, 4'h3, 3, $urandom, 8'h09, 16'h0909);
        run_mwr(1'b0, 64'h480, 10'd3, 4'h8, 4'h1, 1, $urandom, 8'h0A, 16'h0A0A);
        checkpoint(1'b1);
        pulse_clr();
        send_drop(mk_hdr(8'h40, 10'd4, 4'hF, 4'hF, 8'h0B, 16'h1, 64'h104), 2);
        exp_err = 1'b1;
        checkpoint(1'b1);
        pulse_clr();
        run_mwr(1'b1, 64'h3FF0, 10'd8, 4'hF, 4'hF, 2, $urandom, 8'h0C, 16'h0C0C);
        run_mwr(1'b0, 64'h0, 10'd0, 4'hF, 4'hF, 256, $urandom, 8'h0D, 16'h0D0D);
        checkpoint(1'b1);

        // Random lengths/enables with backpressure and gaps
        hold_en = 1'b1;
        gap_en  = 1'b1;
        for (int t = 0; t < 32; t++) begin
            int len;
            bit is4;
            logic [63:0] a;
            len = $urandom_range(1, 40);
            is4 = $urandom_range(0, 1) == 1;
            a = is4 ? {32'($urandom), 32'($urandom)} : {32'h0, 32'($urandom)};
            a[3:0] = 4'h0;
            run_mwr(is4, a, 10'(len), 4'($urandom), 4'($urandom), (len + 3) / 4,
                    $urandom, 8'($urandom), 16'($urandom));
        end
        checkpoint(1'b1);

        // 64 TLPs of 32 DW
        done0 = done_seen;
        for (int t = 0; t < 64; t++) begin
            logic [63:0] a;
            a = {32'h0, 32'($urandom)};
            a[3:0] = 4'h0;
            run_mwr(t[0], a, 10'd32, 4'hF, 4'hF, 8, $urandom, 8'($urandom), 16'($urandom));
        end
        checkpoint(1'b1);
        chk("done_pulses_64", 64'(done_seen - done0), 64'd64);

        // Reset in the middle of a TLP: beat presented with rst must not be written
        hold_en = 1'b0;
        gap_en  = 1'b0;
        begin
            logic [127:0] d0, d1;
            d0 = {$urandom, $urandom, $urandom, $urandom};
            d1 = {$urandom, $urandom, $urandom, $urandom};
            sb.push_back(mk_exp(d0, 0, 32, 4'hF, 4'hF, 10'h050, 1'b0, 10'd32, 8'h0E, 16'h0E0E));
            sb.push_back(mk_exp(d1, 1, 32, 4'hF, 4'hF, 10'h050, 1'b0, 10'd32, 8'h0E, 16'h0E0E));
            drive_beat(mk_hdr(8'h40, 10'd32, 4'hF, 4'hF, 8'h0E, 16'h0E0E, 64'h500), 1'b0);
            drive_beat(d0, 1'b0);
            drive_beat(d1, 1'b0);
            @(negedge clk);
            bus.tdata = {$urandom, $urandom, $urandom, $urandom};
            bus.tvld  = 1'b1;
            bus.tlast = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            bus.tvld = 1'b0;
            chk("midrst_trdy", 64'(bus.trdy), 64'd0);
            chk("midrst_wr_en", 64'(o_wr_en), 64'd0);
            @(negedge clk);
            rst = 1'b0;
        end
        exp_drop = 0;
        exp_err  = 1'b0;
        checkpoint(1'b1);
        chk("midrst_wr_addr", 64'(o_wr_addr), 64'd0);
        chk("midrst_info", 64'({o_tlp_len, o_tlp_tag, o_tlp_req_id}), 64'd0);
        run_mwr(1'b0, 64'h500, 10'd32, 4'hF, 4'hF, 8, $urandom, 8'h0F, 16'h0F0F);
        checkpoint(1'b1);
        chk("post_rst_len", 64'(o_tlp_len), 64'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
